// File: rtl/game_result_pkg.sv
// rtl/game_result_pkg.sv - shared encodings, state type and record layout for the game result logger
package game_result_pkg;

    localparam logic [1:0] WHO_WIN  = 2'b01;
    localparam logic [1:0] WHO_LOSE = 2'b10;
    localparam logic [3:0] CNT_MAX  = 4'd15;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    // Fixed-width head of every record; game index (and optional timestamp) follow it.
    typedef struct packed {
        logic [1:0] who;
        logic [3:0] win_cnt;
        logic [3:0] lose_cnt;
    } result_rec_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + 4'd1 : v;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - result record FIFO with push/full input side and valid/ready output side
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    output logic                       full_o,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [W-1:0]               pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    logic          pop, wr;

    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign pop_valid_o = (count_q != '0);
    assign pop         = pop_valid_o && pop_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign wr          = push_i && (!full_o || pop);
    assign pop_data_o  = pop_valid_o ? mem_q[rd_q] : '0;
    assign count_o     = count_q;

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr)  wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            case ({wr, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/game_result_logger.sv
// rtl/game_result_logger.sv - per-game tally, result record FIFO and match tallies; RESULT_TIMESTAMP_EN appends a 16-bit cycle stamp
module game_result_logger
    import game_result_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int IDX_W   = 8,
    parameter int TALLY_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     INIT,
    input  logic                     WINNER,
    input  logic                     LOSER,
    input  logic                     GAMEOVER,
    input  logic [1:0]               WHO,
    output logic                     rec_valid,
    input  logic                     rec_ready,
`ifdef RESULT_TIMESTAMP_EN
    output logic [IDX_W+25:0]        rec_data,
`else
    output logic [IDX_W+9:0]         rec_data,
`endif
    output logic [TALLY_W-1:0]       win_games,
    output logic [TALLY_W-1:0]       lose_games,
    output logic                     bad_who,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);
`ifdef RESULT_TIMESTAMP_EN
    localparam int REC_W = IDX_W + 26;
`else
    localparam int REC_W = IDX_W + 10;
`endif

    state_t             state_q, state_d;
    logic [3:0]         win_q, win_d, lose_q, lose_d, win_inc, lose_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gov_q, gov_d, capture;
    logic [TALLY_W-1:0] win_games_q, win_games_d, lose_games_q, lose_games_d;
    logic               bad_q, bad_d, drop_q, drop_d;
    logic               push_q;
    logic [REC_W-1:0]   rec_q, rec_d;
    result_rec_t        hdr;
    logic               fifo_full, pop;

`ifdef RESULT_TIMESTAMP_EN
    logic [15:0] ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 16'd1;
    end
`endif

    always_comb begin
        win_inc      = sat_inc4(win_q, WINNER);
        lose_inc     = sat_inc4(lose_q, LOSER);
        state_d      = state_q;
        win_d        = win_q;
        lose_d       = lose_q;
        idx_d        = idx_q;
        gov_d        = GAMEOVER;
        capture      = 1'b0;
        win_games_d  = win_games_q;
        lose_games_d = lose_games_q;
        bad_d        = bad_q;
        case (state_q)
            PLAY: begin
                win_d  = win_inc;
                lose_d = lose_inc;
                if (GAMEOVER && !gov_q) begin
                    capture = 1'b1;
                    state_d = OVER;
                end
                // INIT with the edge closes the game and starts the next one in the same step.
                if (INIT) begin
                    win_d  = '0;
                    lose_d = '0;
                    gov_d  = 1'b0;
                    if (capture) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = PLAY;
                    end
                end
            end
            OVER: begin
                if (INIT) begin
                    win_d   = '0;
                    lose_d  = '0;
                    gov_d   = 1'b0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
        if (capture) begin
            if (WHO == WHO_WIN) begin
                if (win_games_q != {TALLY_W{1'b1}}) win_games_d = win_games_q + TALLY_W'(1);
            end else if (WHO == WHO_LOSE) begin
                if (lose_games_q != {TALLY_W{1'b1}}) lose_games_d = lose_games_q + TALLY_W'(1);
            end else begin
                bad_d = 1'b1;
            end
        end
        hdr.who      = WHO;
        hdr.win_cnt  = win_inc;
        hdr.lose_cnt = lose_inc;
`ifdef RESULT_TIMESTAMP_EN
        rec_d = {hdr, idx_q, ts_q};
`else
        rec_d = {hdr, idx_q};
`endif
    end

    assign pop    = rec_valid && rec_ready;
    assign drop_d = drop_q | (push_q && fifo_full && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLAY;
            win_q        <= '0;
            lose_q       <= '0;
            idx_q        <= '0;
            gov_q        <= 1'b0;
            win_games_q  <= '0;
            lose_games_q <= '0;
            bad_q        <= 1'b0;
            drop_q       <= 1'b0;
            push_q       <= 1'b0;
            rec_q        <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            idx_q        <= idx_d;
            gov_q        <= gov_d;
            win_games_q  <= win_games_d;
            lose_games_q <= lose_games_d;
            bad_q        <= bad_d;
            drop_q       <= drop_d;
            push_q       <= capture;
            if (capture) rec_q <= rec_d;
        end
    end

    result_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_q),
        .push_data_i (rec_q),
        .full_o      (fifo_full),
        .pop_valid_o (rec_valid),
        .pop_ready_i (rec_ready),
        .pop_data_o  (rec_data),
        .count_o     (count)
    );

    assign win_games  = win_games_q;
    assign lose_games = lose_games_q;
    assign bad_who    = bad_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_game_result_logger.sv
// tb/tb_game_result_logger.sv - directed scoreboard bench for game_result_logger
module tb_game_result_logger;
    localparam int DEPTH   = 4;
    localparam int IDX_W   = 8;
    localparam int TALLY_W = 8;
    localparam int REC_W   = IDX_W + 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic INIT = 1'b0, WINNER = 1'b0, LOSER = 1'b0, GAMEOVER = 1'b0;
    logic [1:0] WHO = 2'b00;
    logic rec_ready = 1'b0;
    logic rec_valid, bad_who, drop;
    logic [REC_W-1:0] rec_data;
    logic [TALLY_W-1:0] win_games, lose_games;
    logic [$clog2(DEPTH):0] count;

    game_result_logger #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TALLY_W(TALLY_W)) dut (
        .clk(clk), .rst_n(rst_n), .INIT(INIT), .WINNER(WINNER), .LOSER(LOSER),
        .GAMEOVER(GAMEOVER), .WHO(WHO), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .win_games(win_games), .lose_games(lose_games),
        .bad_who(bad_who), .drop(drop), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [REC_W-1:0] sb[$];
    int m_win, m_lose, m_wg, m_lg;
    logic [IDX_W-1:0] m_idx;
    logic m_bad, m_drop;
    bit m_play;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] rec_of(input logic [1:0] who);
        logic [3:0] w, l;
        w = m_win[3:0];
        l = m_lose[3:0];
        return {who, w, l, m_idx};
    endfunction

    function automatic void model_tally(input logic [1:0] who);
        if (who == 2'b01) begin
            if (m_wg < 255) m_wg++;
        end else if (who == 2'b10) begin
            if (m_lg < 255) m_lg++;
        end else begin
            m_bad = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_win = 0; m_lose = 0; m_wg = 0; m_lg = 0;
        m_idx = '0; m_bad = 1'b0; m_drop = 1'b0; m_play = 1'b1;
    endfunction

    task automatic pulse(input logic w, input logic l);
        WINNER = w; LOSER = l;
        tick();
        WINNER = 1'b0; LOSER = 1'b0;
        if (m_play) begin
            if (w && m_win < 15) m_win++;
            if (l && m_lose < 15) m_lose++;
        end
    endtask

    task automatic start_game();
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        if (!m_play) m_idx++;
        m_win = 0; m_lose = 0; m_play = 1'b1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(sb.size()));
        chk({tag, "_win_games"}, 32'(win_games), 32'(m_wg));
        chk({tag, "_lose_games"}, 32'(lose_games), 32'(m_lg));
        chk({tag, "_bad_who"}, 32'(bad_who), 32'(m_bad));
        chk({tag, "_drop"}, 32'(drop), 32'(m_drop));
    endtask

    task automatic end_game(input logic [1:0] who, input bit pop_same);
        logic [REC_W-1:0] e;
        GAMEOVER = 1'b1; WHO = who;
        tick();
        GAMEOVER = 1'b0; WHO = 2'b00;
        e = rec_of(who);
        model_tally(who);
        m_play = 1'b0;
        if (sb.size() == 0) chk("latency_one_cycle_valid", 32'(rec_valid), 32'd0);
        if (pop_same && sb.size() != 0) begin
            rec_ready = 1'b1;
            chk("pop_with_push_head", 32'(rec_data), 32'(sb.pop_front()));
            sb.push_back(e);
            tick();
            rec_ready = 1'b0;
        end else begin
            if (sb.size() < DEPTH) sb.push_back(e);
            else m_drop = 1'b1;
            tick();
        end
        chk("latency_two_cycle_valid", 32'(rec_valid), 32'd1);
        check_status("end_game");
    endtask

    task automatic drain_one();
        logic [REC_W-1:0] e;
        int n = 0;
        while (!rec_valid && n < 20) begin
            tick();
            n++;
        end
        chk("drain_valid", 32'(rec_valid), 32'd1);
        if (rec_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("drain_data", 32'(rec_data), 32'(e));
            tick();
            chk("drain_data_hold", 32'(rec_data), 32'(e));
            rec_ready = 1'b1;
            tick();
            rec_ready = 1'b0;
        end
    endtask

    task automatic drain_all();
        while (sb.size() != 0) drain_one();
        chk("drained_valid", 32'(rec_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick();
        tick();
        chk("reset_valid", 32'(rec_valid), 32'd0);
        chk("reset_data", 32'(rec_data), 32'd0);
        check_status("reset");
        rst_n = 1'b1;
        tick();

        // basic game: 3 wins, 2 losses, winner side
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
        end_game(2'b01, 1'b0);
        chk("first_record_const", 32'(rec_data), 32'h13200);
        chk("first_win_games", 32'(win_games), 32'd1);
        drain_all();

        // saturation, then pulses while OVER must not leak into next game
        start_game();
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
        end_game(2'b10, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1);
        start_game();
        pulse(1'b1, 1'b0);
        end_game(2'b01, 1'b0);
        drain_all();

        // aborted game: INIT in PLAY clears counts, keeps index
        start_game();
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        start_game();
        pulse(1'b1, 1'b0);
        end_game(2'b01, 1'b0);
        drain_all();

        // fill the FIFO, then a push that coincides with a pop
        for (int g = 0; g < 4; g++) begin
            start_game();
            for (int i = 0; i <= g; i++) pulse(1'b0, 1'b1);
            end_game(2'b10, 1'b0);
        end
        start_game();
        pulse(1'b1, 1'b1);
        end_game(2'b01, 1'b1);
        chk("full_pop_count", 32'(count), 32'd4);
        chk("full_pop_no_drop", 32'(drop), 32'd0);
        drain_all();

        // overflow: fifth record dropped, earlier four intact
        for (int g = 0; g < 5; g++) begin
            start_game();
            for (int i = 0; i < g; i++) pulse(1'b1, 1'b0);
            end_game(2'b01, 1'b0);
        end
        chk("overflow_drop", 32'(drop), 32'd1);
        chk("overflow_count", 32'(count), 32'd4);
        drain_all();

        // GAMEOVER edge, INIT and WINNER all in one cycle
        start_game();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        WINNER = 1'b1; GAMEOVER = 1'b1; INIT = 1'b1; WHO = 2'b01;
        tick();
        WINNER = 1'b0; GAMEOVER = 1'b0; INIT = 1'b0; WHO = 2'b00;
        m_win++;
        sb.push_back(rec_of(2'b01));
        model_tally(2'b01);
        m_idx++; m_win = 0; m_lose = 0; m_play = 1'b1;
        tick();
        chk("coincide_valid", 32'(rec_valid), 32'd1);
        check_status("coincide");
        pulse(1'b0, 1'b1);
        end_game(2'b10, 1'b0);
        drain_all();

        // invalid WHO, then asynchronous reset with records pending
        start_game();
        pulse(1'b1, 1'b0);
        end_game(2'b11, 1'b0);
        chk("bad_who_set", 32'(bad_who), 32'd1);
        start_game();
        end_game(2'b01, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_valid", 32'(rec_valid), 32'd0);
        chk("async_reset_data", 32'(rec_data), 32'd0);
        check_status("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        pulse(1'b1, 1'b0);
        end_game(2'b01, 1'b0);
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_result_logger.md
Name: game_result_logger

Overview:
Downstream consumer of the counter-game DUT outputs (WINNER, LOSER, GAMEOVER, WHO) and of the driver-side INIT.
- Tallies WINNER/LOSER pulses within the current game.
- On each game end, pushes a result record into a small FIFO drained through a valid/ready port.
- Keeps cumulative match tallies per outcome.
- Used as the result collector between the game DUT and the bench/scoreboard or a host readout.

Parameters:
DEPTH, 4, result FIFO entries (power of 2, >=2)
IDX_W, 8, game index width (wraps)
TALLY_W, 8, width of cumulative match tallies (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
INIT  in  1  game (re)start; clears per-game counters
WINNER  in  1  one-cycle pulse from DUT: winner event
LOSER  in  1  one-cycle pulse from DUT: loser event
GAMEOVER  in  1  level from DUT; game ended while high
WHO  in  2  outcome code from DUT: 2'b01 winner side, 2'b10 loser side, others invalid
rec_valid  out  1  FIFO head record available
rec_ready  in  1  consumer accepts head record
rec_data  out  10+IDX_W  {who[1:0], win_cnt[3:0], lose_cnt[3:0], game_idx}
win_games  out  TALLY_W  games ended with WHO=01
lose_games  out  TALLY_W  games ended with WHO=10
bad_who  out  1  sticky: a game ended with WHO not in {01,10}
drop  out  1  sticky: record lost because FIFO was full
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, asynchronous, rst_n low:
  - All counters, tallies and stickies are 0; game_idx is 0.
  - FIFO is empty, so rec_valid=0 and count=0.
  - rec_data is 0 while empty.
- Per-game counters, 4-bit:
  - win_cnt increments on each WINNER pulse; lose_cnt increments on each LOSER pulse.
  - Both saturate at 15.
  - WINNER and LOSER in the same cycle increment both.
  - Pulses are ignored while the state is OVER.
- State machine:
  - PLAY: a GAMEOVER rising edge (GAMEOVER=1 and registered previous value 0) captures a record and moves to OVER.
  - OVER: waits for INIT=1; INIT clears win_cnt, lose_cnt and GAMEOVER history, increments game_idx (mod 2^IDX_W), and returns to PLAY.
  - INIT in PLAY clears the counters and stays in PLAY; game_idx is unchanged (aborted game, no record).
- Record capture:
  - Uses the counter values including any WINNER/LOSER pulse in the same cycle as the GAMEOVER edge.
  - If INIT coincides with the GAMEOVER edge: the record is captured with pre-clear values, then the clear applies and the state goes to OVER→PLAY in one step, with game_idx incremented.
- Tallies at capture:
  - WHO=01 increments win_games; WHO=10 increments lose_games. Both saturate at all-ones.
  - Any other WHO sets bad_who; the record is still stored with the raw WHO.
- FIFO:
  - Push happens on the cycle after capture (registered); latency from GAMEOVER edge to rec_valid is 2 cycles when the FIFO was empty.
  - Pop occurs when rec_valid && rec_ready.
  - rec_data is stable while rec_valid && !rec_ready.
  - Full with no pop: the push is dropped and drop is set. Full with pop in the same cycle: the push is accepted.
  - Empty with push: no same-cycle bypass.
  - count is updated every cycle.
- Stickies clear only on reset.
- rst_n assertion mid-game or mid-handshake immediately empties the FIFO and drops rec_valid.

Optional Feature:
RESULT_TIMESTAMP_EN
- Defined:
  - Adds a free-running 16-bit cycle counter, reset to 0, wrapping.
  - Its value at the GAMEOVER edge is appended as the LSBs of rec_data, so rec_data width becomes 26+IDX_W.
- Undefined: no timestamp logic, and rec_data is 10+IDX_W bits.

Decomposition:
- Package game_result_pkg holds:
  - WHO encodings (WHO_WIN=2'b01, WHO_LOSE=2'b10)
  - state enum (PLAY, OVER)
  - CNT_MAX=4'd15
  - packed struct result_rec_t
- Sub-module result_fifo (parameterised DEPTH and width, valid/ready pop, push/full, count) is natural; the top instantiates it once.

Test Plan:
- WINNER×3 then LOSER×2 then GAMEOVER rises with WHO=01 → 2 cycles later rec_valid=1, rec_data={01,3,2,0}, win_games=1.
- 20 WINNER pulses, then GAMEOVER with WHO=10 → win_cnt in record=15 (saturated), lose_games=1; further pulses while OVER do not change the next record's counts after INIT.
- Five games ended with rec_ready=0 and DEPTH=4 → count=4, drop=1, first four records hold game_idx 0..3; draining yields them in order.
- Full FIFO, rec_ready=1 on the same cycle as a new push → count stays 4, drop stays 0, newest record appears last.
- GAMEOVER edge and INIT in the same cycle with WINNER pulse → record has the count including that pulse; next cycle counters=0, game_idx=1, state PLAY.
- WHO=11 at game end → bad_who=1, no tally changes; rst_n pulsed low mid-stream → rec_valid=0, count=0, stickies cleared asynchronously.
